dcache_ctrl: RTL

- Data-cache controller sitting between the EX/MEM pipeline register (CPU side) and the off-chip data memory (memory side).
- Direct-mapped, write-back, write-allocate cache.
- Generates the stall signal that freezes every pipeline register on a miss and releases it once the line is resident.
- Hits complete in the same cycle with no stall; misses run a writeback/refill handshake with memory.

---
 rtl/dcache_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller with pipeline stall generation.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_ctrl #(
    parameter int NUM_LINES      = 32,
    parameter int WORDS_PER_LINE = 4,
    localparam int LINE_BITS     = 32 * WORDS_PER_LINE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic                 cpu_memread_i,
    input  logic                 cpu_memwrite_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int OFF_WS = (OFF_W > 0) ? OFF_W : 1;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWriteback = 2'd1;
    localparam logic [1:0] StAllocate  = 2'd2;

    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [1:0]           state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]     lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]     lat_idx_q, lat_idx_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [OFF_WS-1:0] off;
    logic              req, hit, write_hit;
    logic              unused_addr;

    assign idx         = cpu_addr_i[2+OFF_W +: IDX_W];
    assign tag         = cpu_addr_i[31 -: TAG_W];
    assign off         = (OFF_W > 0) ? cpu_addr_i[2 +: OFF_WS] : '0;
    assign unused_addr = ^cpu_addr_i[1:0];

    assign req       = cpu_memread_i | cpu_memwrite_i;
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    assign write_hit = (state_q == StIdle) & cpu_memwrite_i & hit;

    // Gated by reset so a held request cannot stall the pipeline while in reset.
    assign stall_o     = rst_i & ((req & ~hit & (state_q == StIdle)) | (state_q != StIdle));
    assign cpu_rdata_o = data_q[idx][off*32 +: 32];

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        lat_tag_d   = lat_tag_q;
        lat_idx_d   = lat_idx_q;
        case (state_q)
            StIdle: begin
                if (req && !hit) begin
                    lat_tag_d = tag;
                    lat_idx_d = idx;
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = StWriteback;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, {(OFF_W+2){1'b0}}};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d    = StAllocate;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag, idx, {(OFF_W+2){1'b0}}};
                    end
                end
            end
            StWriteback: begin
                if (mem_ack_i) begin
                    state_d    = StAllocate;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {lat_tag_q, lat_idx_q, {(OFF_W+2){1'b0}}};
                end
            end
            StAllocate: begin
                if (mem_ack_i) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lat_tag_q   <= '0;
            lat_idx_q   <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            lat_tag_q   <= lat_tag_d;
            lat_idx_q   <= lat_idx_d;
            if (write_hit) begin
                dirty_q[idx] <= 1'b1;
            end
            if (state_q == StAllocate && mem_ack_i) begin
                valid_q[lat_idx_q] <= 1'b1;
                dirty_q[lat_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk_i) begin
        if (write_hit) begin
            data_q[idx][off*32 +: 32] <= cpu_wdata_i;
        end
        if (state_q == StAllocate && mem_ack_i) begin
            data_q[lat_idx_q] <= mem_rdata_i;
            tag_q[lat_idx_q]  <= lat_tag_q;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_event, miss_event;

    assign hit_event  = (state_q == StIdle) & req & hit;
    assign miss_event = (state_q == StIdle) & (state_d != StIdle);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_event && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_event && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule
